// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that streams one 4-bit slice per cycle through a
// four_bit_parallel_adder and chains the carry through a flip-flop.

module four_bit_parallel_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum     = total_s[3:0];
    assign cout    = total_s[4];

endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    parameter int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       sum_s;
    logic             cout_s;

    // Select the operand slice addressed by the nibble counter.
    always_comb begin
        a_nib_s = 4'h0;
        b_nib_s = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            a_nib_s = a_nib_s | (a_r[4*i +: 4] & {4{cnt_r == CW'(i)}});
            b_nib_s = b_nib_s | (b_r[4*i +: 4] & {4{cnt_r == CW'(i)}});
        end
    end

    four_bit_parallel_adder u_slice (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Control FSM with operand capture, sum assembly and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= Cin;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt_r == CW'(i)) begin
                            S[4*i +: 4] <= sum_s;
                        end
                    end
                    carry_r <= cout_s;
                    // Final slice: capture the carry-out and flag completion.
                    if (cnt_r == LAST) begin
                        Cout    <= cout_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance.

module tb_nibble_serial_adder;

    typedef struct {
        logic [16:0] res;
        int          due;
    } exp4_t;

    typedef struct {
        logic [4:0] res;
        int         due;
    } exp1_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic [15:0] A4 = 16'h0000;
    logic [15:0] B4 = 16'h0000;
    logic        Cin4 = 1'b0;
    logic        busy4, done4, Cout4;
    logic [15:0] S4;
    logic        start1 = 1'b0;
    logic [3:0]  A1 = 4'h0;
    logic [3:0]  B1 = 4'h0;
    logic        Cin1 = 1'b0;
    logic        busy1, done1, Cout1;
    logic [3:0]  S1;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    run4 = 0;
    int    last_run4 = 0;
    logic  prev_done4 = 1'b0;
    logic  prev_done1 = 1'b0;
    exp4_t q4[$];
    exp1_t q1[$];

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Cin(Cin4),
        .busy(busy4), .done(done4), .S(S4), .Cout(Cout4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
        .busy(busy1), .done(done1), .S(S1), .Cout(Cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitors: pop the scoreboard whenever done is seen.
    always @(negedge clk) begin
        exp4_t e4;
        exp1_t e1;
        if (done4) begin
            if (prev_done4) check("done4_width", 32'(prev_done4), 32'd0);
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("S4", 32'(S4), 32'(e4.res[15:0]));
                check("Cout4", 32'(Cout4), 32'(e4.res[16]));
                check("lat4", 32'(cyc), 32'(e4.due));
            end
        end
        prev_done4 = done4;
        if (busy4) begin
            run4++;
        end else if (run4 > 0) begin
            last_run4 = run4;
            run4 = 0;
        end
        if (done1) begin
            if (prev_done1) check("done1_width", 32'(prev_done1), 32'd0);
            if (q1.size() == 0) begin
                check("done1_unexpected", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("S1", 32'(S1), 32'(e1.res[3:0]));
                check("Cout1", 32'(Cout1), 32'(e1.res[4]));
                check("lat1", 32'(cyc), 32'(e1.due));
            end
        end
        prev_done1 = done1;
    end

    task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp4_t e;
        @(negedge clk);
        A4 = a; B4 = b; Cin4 = cin; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        e.res = {1'b0, a} + {1'b0, b} + 17'(cin);
        e.due = cyc + 4;
        q4.push_back(e);
        check("busy4_accept", 32'(busy4), 32'd1);
        A4 = ~a; B4 = 16'($urandom); Cin4 = ~cin;
    endtask

    task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        exp1_t e;
        @(negedge clk);
        A1 = a; B1 = b; Cin1 = cin; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        e.res = {1'b0, a} + {1'b0, b} + 5'(cin);
        e.due = cyc + 1;
        q1.push_back(e);
        check("busy1_accept", 32'(busy1), 32'd1);
        check("done1_early", 32'(done1), 32'd0);
        A1 = ~a;
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((q4.size() != 0 || busy4) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("idle4", {30'd0, busy4, q4.size() != 0}, 32'd0);
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((q1.size() != 0 || busy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("idle1", {30'd0, busy1, q1.size() != 0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp4_t e;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_S4", 32'(S4), 32'd0);
        check("rst_Cout4", 32'(Cout4), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;

        issue4(16'h1234, 16'h4321, 1'b0);
        wait_idle4();
        check("busy4_len", 32'(last_run4), 32'd5);

        issue4(16'hFFFF, 16'h0001, 1'b0);
        wait_idle4();
        issue4(16'h0000, 16'h0000, 1'b1);
        wait_idle4();
        issue4(16'h7FF8, 16'h8007, 1'b1);
        wait_idle4();

        // Request held high through busy: second operands taken only in IDLE.
        @(negedge clk);
        A4 = 16'h00FF; B4 = 16'h0001; Cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        e.res = 17'h00100; e.due = cyc + 4;  q4.push_back(e);
        e.res = 17'h0FFFF; e.due = cyc + 10; q4.push_back(e);
        A4 = 16'hAAAA; B4 = 16'h5555;
        repeat (6) @(posedge clk);
        #1;
        start4 = 1'b0;
        check("busy4_second", 32'(busy4), 32'd1);
        wait_idle4();

        // Reset mid-operation discards the result.
        @(negedge clk);
        A4 = 16'h1111; B4 = 16'h2222; Cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy4", 32'(busy4), 32'd0);
        check("midrst_done4", 32'(done4), 32'd0);
        check("midrst_S4", 32'(S4), 32'd0);
        check("midrst_Cout4", 32'(Cout4), 32'd0);
        repeat (8) @(negedge clk);
        issue4(16'h0003, 16'h0005, 1'b0);
        wait_idle4();

        for (int k = 0; k < 5; k++) begin
            issue4(16'($urandom), 16'($urandom), 1'($urandom));
            wait_idle4();
        end

        issue1(4'hF, 4'h1, 1'b0);
        wait_idle1();
        issue1(4'h7, 4'h8, 1'b1);
        wait_idle1();
        issue1(4'h3, 4'h4, 1'b0);
        wait_idle1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Wide adder built as a sequential wrapper around the existing four_bit_parallel_adder.
- Sits directly upstream of that adder. It latches two WIDTH-bit operands and feeds one 4-bit nibble pair per cycle, LSB nibble first.
- The carry is chained between cycles through a flip-flop.
- It assembles the WIDTH-bit sum and final carry, and reports completion with a one-cycle done pulse.

Parameters:
- NIBBLES, 4, number of 4-bit slices; also the number of add cycles.
- WIDTH, 4*NIBBLES, operand/sum width (derived; not overridden independently).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry into nibble 0; captured with A/B.
- busy  output  1  high from the accepting edge until the return to IDLE (ADD and DONE states).
- done  output  1  one-cycle pulse; S/Cout are valid while it is high.
- S  output  WIDTH  sum register.
- Cout  output  1  carry out of the top nibble.

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE, busy=0, done=0, S=0, Cout=0, nibble counter=0, carry flop=0, operand registers=0. Reset has priority over every other input, including mid-operation; any in-flight operation is discarded with no done pulse.
- States: IDLE, ADD, DONE (registered, one-hot or binary at implementer's choice).
- IDLE:
  - start=1 at edge e0: latch A, B, Cin; counter=0; go to ADD; busy=1 after e0.
  - start=0: stay in IDLE.
- ADD:
  - On each edge, compute nibble i = counter from latched A[4i+3:4i], B[4i+3:4i] and the carry flop, via four_bit_parallel_adder.
  - Write the result to S[4i+3:4i] and its carry to the carry flop; counter increments.
  - When i = NIBBLES-1, also load Cout from the adder carry and go to DONE.
- Nibble i is written on edge e0+i+1.
- Last nibble written on edge e0+NIBBLES; done=1 for the cycle following that edge.
- Latency: start edge to done visible = NIBBLES cycles.
- DONE: next edge returns to IDLE; done=0, busy=0.
- start is ignored in DONE; the earliest next accept is the first IDLE cycle. Holding start high gives one operation per NIBBLES+2 cycles.
- start during ADD/DONE: ignored; latched operands are unaffected.
- A/B/Cin changes after the accepting edge have no effect.
- S may show partially updated upper nibbles while busy; the consumer samples only on done.
- S and Cout hold their values after DONE until the next accepted operation.
- Cout changes only on the final ADD edge or on reset.
- Arithmetic is unsigned modulo 2^WIDTH; {Cout,S} = A + B + Cin exactly.
- Counter width: clog2(NIBBLES), minimum 1; no wrap beyond NIBBLES-1.
- NIBBLES=1 is legal: one ADD cycle, done one cycle after start.

Test Plan:
1. NIBBLES=4, A=16'h1234, B=16'h4321, Cin=0, start pulsed at edge e0 -> done high exactly one cycle, after edge e0+4; S=16'h5555, Cout=0; busy high for 5 cycles.
2. A=16'hFFFF, B=16'h0001, Cin=0 -> carry ripples through all four cycles; S=16'h0000, Cout=1.
3. A=16'h0000, B=16'h0000, Cin=1 -> S=16'h0001, Cout=0. Follow with A=16'h7FF8, B=16'h8007, Cin=1 -> S=16'h0000, Cout=1.
4. Start with A=16'h00FF, B=16'h0001, Cin=0. While busy, drive start=1 with A=16'hAAAA, B=16'h5555 -> result S=16'h0100, Cout=0; the second request is not taken. With start held high, the next accept occurs in the first IDLE cycle and yields S=16'hFFFF, Cout=0.
5. Start with A=16'h1111, B=16'h2222. Assert rst for one edge after 2 ADD cycles -> next cycle busy=0, done=0, S=0, Cout=0, and no done pulse follows. A fresh start with A=16'h0003, B=16'h0005, Cin=0 gives S=16'h0008 after 4 cycles.
6. NIBBLES=1 instance: A=4'hF, B=4'h1, Cin=0 -> done one cycle after start, S=4'h0, Cout=1.
